// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Time-shares one WIDTH-bit adder (sum, carry, signed overflow) between
// NUM_REQ requesters. The grant is round-robin and both the request and the
// response sides use valid/ready handshakes. Operands are registered before
// the adder and the results are registered after it, so each transaction
// takes IDLE -> CALC -> RESP.
module adder_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     rsp_of
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand_idx;
    logic             grant_found;
    int               cand;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   sum_full;
    logic             sum_of;

    // Search for the first valid requester after last_grant, wrapping around,
    // so the most recently served requester has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_grant) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Operand mux: only the slice belonging to the winning requester is used.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // The shared adder; carry and overflow are derived independently.
    always_comb begin
        sum_full = {1'b0, op_a} + {1'b0, op_b};
        sum_of   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                   (sum_full[WIDTH-1] != op_a[WIDTH-1]);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the one-hot accept strobe, which is only raised in IDLE.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = CALC;
                end
            end
            CALC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, result registers and the fairness pointer; last_grant
    // moves only once a response has been handed off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            gnt_id     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            rsp_of     <= 1'b0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        gnt_id <= grant_idx;
                    end
                end
                CALC: begin
                    rsp_sum   <= sum_full[WIDTH-1:0];
                    rsp_carry <= sum_full[WIDTH];
                    rsp_of    <= sum_of;
                    rsp_id    <= gnt_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
